// File: rtl/crtc_mode_loader_pkg.sv
// rtl/crtc_mode_loader_pkg.sv - states, CRTC register map and bus encodings shared by the mode loader
// ST_ARM exists only when CRTC_LOADER_VSYNC_ALIGN_EN is defined.
package crtc_pkg;

    localparam int CRTC_NUM_REGS = 16;

    localparam logic [3:0] R_HTOTAL       = 4'd0;
    localparam logic [3:0] R_HDISP        = 4'd1;
    localparam logic [3:0] R_HSYNC_POS    = 4'd2;
    localparam logic [3:0] R_SYNC_WIDTH   = 4'd3;
    localparam logic [3:0] R_VTOTAL       = 4'd4;
    localparam logic [3:0] R_VTOTAL_ADJ   = 4'd5;
    localparam logic [3:0] R_VDISP        = 4'd6;
    localparam logic [3:0] R_VSYNC_POS    = 4'd7;
    localparam logic [3:0] R_INTERLACE    = 4'd8;
    localparam logic [3:0] R_MAX_RASTER   = 4'd9;
    localparam logic [3:0] R_CURSOR_START = 4'd10;
    localparam logic [3:0] R_CURSOR_END   = 4'd11;
    localparam logic [3:0] R_START_H      = 4'd12;
    localparam logic [3:0] R_START_L      = 4'd13;
    localparam logic [3:0] R_CURSOR_H     = 4'd14;
    localparam logic [3:0] R_CURSOR_L     = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RESTORE,
        ST_CPU_CYC
`ifdef CRTC_LOADER_VSYNC_ALIGN_EN
        , ST_ARM
`endif
    } loader_state_t;

    typedef struct packed {
        logic       enable;
        logic       ncs;
        logic       r_nw;
        logic       rs;
        logic [7:0] di;
    } crtc_bus_t;

    localparam logic      BUS_IDLE_ENABLE = 1'b0;
    localparam logic      BUS_IDLE_NCS    = 1'b1;
    localparam logic      BUS_IDLE_R_NW   = 1'b1;
    localparam crtc_bus_t BUS_IDLE = '{enable: BUS_IDLE_ENABLE, ncs: BUS_IDLE_NCS,
                                       r_nw: BUS_IDLE_R_NW, rs: 1'b0, di: 8'h00};

    function automatic crtc_bus_t bus_cycle(input logic r_nw, input logic rs, input logic [7:0] di);
        crtc_bus_t b;
        b.enable = 1'b1;
        b.ncs    = 1'b0;
        b.r_nw   = r_nw;
        b.rs     = rs;
        b.di     = di;
        return b;
    endfunction

endpackage

// File: rtl/crtc_mode_loader_if.sv
// rtl/crtc_mode_loader_if.sv - CPU-side register access port of the CRTC mode loader
interface crtc_mode_loader_if;
    logic       CPU_REQ;
    logic       CPU_WE;
    logic       CPU_RS;
    logic [7:0] CPU_DI;
    logic [7:0] CPU_DO;
    logic       CPU_ACK;
    logic       CPU_WAIT;

    modport master (
        output CPU_REQ, CPU_WE, CPU_RS, CPU_DI,
        input  CPU_DO, CPU_ACK, CPU_WAIT
    );

    modport slave (
        input  CPU_REQ, CPU_WE, CPU_RS, CPU_DI,
        output CPU_DO, CPU_ACK, CPU_WAIT
    );
endinterface

// File: rtl/crtc_mode_loader.sv
// rtl/crtc_mode_loader.sv - streams a mode table into the CRTC and arbitrates CPU register accesses
// Optional VSYNC-aligned load start: CRTC_LOADER_VSYNC_ALIGN_EN.
module crtc_mode_loader
    import crtc_pkg::*;
#(
    parameter int MODE_W     = 2,
    parameter int NUM_REGS   = CRTC_NUM_REGS,
    parameter int AUTOLOAD   = 1,
    parameter int RESET_MODE = 0
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [MODE_W-1:0]   MODE_SEL,
    input  logic                MODE_LOAD,
    output logic                BUSY,
    output logic                DONE,
    output logic [MODE_W+3:0]   TBL_ADDR,
    input  logic [7:0]          TBL_DATA,
    crtc_mode_loader_if.slave   cpu,
    output logic                CRTC_ENABLE,
    output logic                CRTC_nCS,
    output logic                CRTC_R_nW,
    output logic                CRTC_RS,
    output logic [7:0]          CRTC_DI,
    input  logic [7:0]          CRTC_DO,
    input  logic                VSYNC
);

    loader_state_t      state_q, state_d;
    crtc_bus_t          bus_q, bus_d;
    logic [MODE_W-1:0]  mode_q, pend_mode, go_mode;
    logic [3:0]         idx_q;
    logic               load_pend, load_go;
    logic               busy_q, done_q, ack_q, wait_q;
    logic [7:0]         do_q;
    logic [4:0]         shadow_q, sh_l;
    logic               we_l, rs_l;
    logic               last_idx;

    assign last_idx = (idx_q == 4'(NUM_REGS - 1));

`ifdef CRTC_LOADER_VSYNC_ALIGN_EN
    logic auto_q, vsync_q;

    // Only the post-reset autoload may bypass VSYNC alignment.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            auto_q  <= (AUTOLOAD != 0);
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= VSYNC;
            if (load_go || (MODE_LOAD && state_q != ST_IDLE)) begin
                auto_q <= 1'b0;
            end
        end
    end
`else
    logic unused_vsync;
    assign unused_vsync = VSYNC;
`endif

    always_comb begin
        state_d = state_q;
        bus_d   = BUS_IDLE;
        load_go = 1'b0;
        go_mode = pend_mode;
        case (state_q)
            ST_IDLE: begin
                // Loads outrank the CPU; REQ is ignored while its ACK is still showing.
                if (MODE_LOAD || load_pend) begin
                    load_go = 1'b1;
                    go_mode = MODE_LOAD ? MODE_SEL : pend_mode;
`ifdef CRTC_LOADER_VSYNC_ALIGN_EN
                    state_d = (!MODE_LOAD && auto_q) ? ST_FETCH : ST_ARM;
`else
                    state_d = ST_FETCH;
`endif
                end else if (cpu.CPU_REQ && !ack_q) begin
                    state_d = ST_CPU_CYC;
                    bus_d   = bus_cycle(!cpu.CPU_WE, cpu.CPU_RS, cpu.CPU_DI);
                end
            end
`ifdef CRTC_LOADER_VSYNC_ALIGN_EN
            ST_ARM: begin
                if (VSYNC && !vsync_q) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            ST_FETCH: begin
                state_d = ST_WR_ADDR;
                bus_d   = bus_cycle(1'b0, 1'b0, 8'(idx_q));
            end
            ST_WR_ADDR: begin
                state_d = ST_WR_DATA;
                bus_d   = bus_cycle(1'b0, 1'b1, TBL_DATA);
            end
            ST_WR_DATA: begin
                if (last_idx) begin
                    state_d = ST_RESTORE;
                    bus_d   = bus_cycle(1'b0, 1'b0, {3'b000, shadow_q});
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_RESTORE: state_d = ST_IDLE;
            ST_CPU_CYC: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bus values are registered on entry so each bus cycle lines up with its state.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            bus_q     <= BUS_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            wait_q    <= 1'b0;
            do_q      <= 8'h00;
            idx_q     <= 4'd0;
            mode_q    <= '0;
            shadow_q  <= 5'd0;
            load_pend <= (AUTOLOAD != 0);
            pend_mode <= MODE_W'(RESET_MODE);
            we_l      <= 1'b0;
            rs_l      <= 1'b0;
            sh_l      <= 5'd0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            done_q  <= (state_q == ST_RESTORE);
            ack_q   <= (state_q == ST_CPU_CYC);
            wait_q  <= cpu.CPU_REQ && !ack_q && (state_q != ST_CPU_CYC) && (state_d != ST_CPU_CYC);

            if (load_go) begin
                busy_q    <= 1'b1;
                idx_q     <= 4'd0;
                mode_q    <= go_mode;
                load_pend <= 1'b0;
            end else if (state_q == ST_RESTORE) begin
                busy_q <= 1'b0;
            end

            if (state_q == ST_WR_DATA && !last_idx) begin
                idx_q <= idx_q + 4'd1;
            end

            // A request arriving mid-load is kept as a single pending load; the latest mode wins.
            if (MODE_LOAD && state_q != ST_IDLE) begin
                load_pend <= 1'b1;
                pend_mode <= MODE_SEL;
            end

            if (state_q == ST_IDLE && state_d == ST_CPU_CYC) begin
                we_l <= cpu.CPU_WE;
                rs_l <= cpu.CPU_RS;
                sh_l <= cpu.CPU_DI[4:0];
            end

            if (state_q == ST_CPU_CYC) begin
                if (!we_l) begin
                    do_q <= CRTC_DO;
                end else if (!rs_l) begin
                    shadow_q <= sh_l;
                end
            end
        end
    end

    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign TBL_ADDR     = {mode_q, idx_q};
    assign cpu.CPU_DO   = do_q;
    assign cpu.CPU_ACK  = ack_q;
    assign cpu.CPU_WAIT = wait_q;
    assign CRTC_ENABLE  = bus_q.enable;
    assign CRTC_nCS     = bus_q.ncs;
    assign CRTC_R_nW    = bus_q.r_nw;
    assign CRTC_RS      = bus_q.rs;
    assign CRTC_DI      = bus_q.di;

endmodule

// File: tb/tb_crtc_mode_loader.sv
// tb/tb_crtc_mode_loader.sv - scoreboard bench for the CRTC mode loader with table ROM and CRTC models
module tb_crtc_mode_loader;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [1:0] MODE_SEL;
    logic       MODE_LOAD;
    logic       BUSY, DONE;
    logic [5:0] TBL_ADDR;
    logic [7:0] TBL_DATA;
    logic       CRTC_ENABLE, CRTC_nCS, CRTC_R_nW, CRTC_RS;
    logic [7:0] CRTC_DI, CRTC_DO;
    logic       VSYNC;

    crtc_mode_loader_if cpu_if();

    crtc_mode_loader dut (
        .CLOCK(CLOCK), .RESET(RESET), .MODE_SEL(MODE_SEL), .MODE_LOAD(MODE_LOAD),
        .BUSY(BUSY), .DONE(DONE), .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA),
        .cpu(cpu_if),
        .CRTC_ENABLE(CRTC_ENABLE), .CRTC_nCS(CRTC_nCS), .CRTC_R_nW(CRTC_R_nW),
        .CRTC_RS(CRTC_RS), .CRTC_DI(CRTC_DI), .CRTC_DO(CRTC_DO), .VSYNC(VSYNC)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_run = 0;
    int busy_len = 0;
    int done_cnt = 0;
    int n_bus    = 0;
    int last_done_cyc = 0;
    logic [9:0] sb[$];
    logic [9:0] sb_exp;
    logic [7:0] crtc_regs [32];
    logic [4:0] crtc_addr = 5'd0;

    function automatic logic [7:0] rom_val(input logic [1:0] m, input logic [3:0] k);
        logic [7:0] m0 [16];
        m0 = '{8'h3F, 8'h28, 8'h2E, 8'h8E, 8'h26, 8'h00, 8'h19, 8'h1E,
               8'h00, 8'h07, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
        if (m == 2'd0) return m0[k];
        return ({2'b00, m, k} * 8'd7) ^ 8'h5A;
    endfunction

    always @(posedge CLOCK) TBL_DATA <= rom_val(TBL_ADDR[5:4], TBL_ADDR[3:0]);

    always @(posedge CLOCK) begin
        if (CRTC_ENABLE && !CRTC_nCS && !CRTC_R_nW) begin
            if (!CRTC_RS) crtc_addr <= CRTC_DI[4:0];
            else          crtc_regs[crtc_addr] <= CRTC_DI;
        end
    end
    assign CRTC_DO = CRTC_RS ? crtc_regs[crtc_addr] : 8'h00;

    always @(posedge CLOCK) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLOCK) begin
        if (CRTC_ENABLE && !CRTC_nCS) begin
            n_bus++;
            if (sb.size() == 0) begin
                check_eq("sb_extra_cycle", sb.size(), 1);
            end else begin
                sb_exp = sb.pop_front();
                check_eq("bus_cycle", {CRTC_R_nW, CRTC_RS, CRTC_DI}, sb_exp);
            end
        end
        if (BUSY) busy_run++;
        else if (busy_run != 0) begin
            busy_len = busy_run;
            busy_run = 0;
        end
        if (DONE) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge CLOCK);
        #1;
    endtask

    task automatic push_load(input logic [1:0] m, input logic [4:0] sh);
        for (int k = 0; k < 16; k++) begin
            sb.push_back({2'b00, 8'(k)});
            sb.push_back({2'b01, rom_val(m, 4'(k))});
        end
        sb.push_back({2'b00, 3'b000, sh});
    endtask

    task automatic pulse_load(input logic [1:0] m);
        MODE_SEL  = m;
        MODE_LOAD = 1'b1;
        tick();
        MODE_LOAD = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 400; i++) begin
            tick();
            if (DONE) break;
        end
        check_eq(tag, DONE, 1);
    endtask

    task automatic cpu_access(input logic we, input logic rs, input logic [7:0] di,
                              output int lat, output int ack_cyc, output logic [7:0] rdata);
        int start;
        tick();
        start = cyc;
        sb.push_back({~we, rs, di});
        cpu_if.CPU_WE  = we;
        cpu_if.CPU_RS  = rs;
        cpu_if.CPU_DI  = di;
        cpu_if.CPU_REQ = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (cpu_if.CPU_ACK) break;
        end
        lat     = cyc - start;
        ack_cyc = cyc;
        rdata   = cpu_if.CPU_DO;
        cpu_if.CPU_REQ = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, ac, d0, n0, vc;
        logic [7:0] rd;
        RESET = 1'b1; MODE_LOAD = 1'b0; MODE_SEL = 2'd0; VSYNC = 1'b0;
        cpu_if.CPU_REQ = 1'b0; cpu_if.CPU_WE = 1'b0; cpu_if.CPU_RS = 1'b0; cpu_if.CPU_DI = 8'h00;
        tick(); tick();
        check_eq("rst_bus", {CRTC_ENABLE, CRTC_nCS, CRTC_R_nW, CRTC_RS, CRTC_DI}, 12'h600);
        check_eq("rst_status", {BUSY, DONE, cpu_if.CPU_ACK, cpu_if.CPU_WAIT}, 4'h0);
        check_eq("rst_tbl_do", {TBL_ADDR, cpu_if.CPU_DO}, 14'h0);

        push_load(2'd0, 5'd0);
        RESET = 1'b0;
        wait_done("auto_done");
        check_eq("auto_busy_len", busy_len, 49);
        check_eq("auto_done_cnt", done_cnt, 1);
        check_eq("auto_drain", sb.size(), 0);
        tick();
        check_eq("done_pulse_width", DONE, 0);

        cpu_access(1'b1, 1'b0, 8'h0C, lat, ac, rd);
        check_eq("cpu_wr_addr_lat", lat, 2);
        cpu_access(1'b1, 1'b1, 8'h30, lat, ac, rd);
        check_eq("cpu_wr_data_lat", lat, 2);
        cpu_access(1'b0, 1'b1, 8'h00, lat, ac, rd);
        check_eq("cpu_rd_lat", lat, 2);
        check_eq("cpu_rd_data", rd, 8'h30);
        check_eq("cpu_drain", sb.size(), 0);

        tick();
        d0 = done_cnt;
        push_load(2'd1, 5'd12);
        pulse_load(2'd1);
        wait_done("m1_done");
        check_eq("m1_busy_len", busy_len, 49);
        check_eq("m1_drain", sb.size(), 0);
        check_eq("m1_restore_addr", crtc_addr, 12);
        check_eq("m1_done_cnt", done_cnt - d0, 1);

        tick();
        push_load(2'd3, 5'd12);
        pulse_load(2'd3);
        repeat (4) tick();
        fork
            cpu_access(1'b1, 1'b1, 8'h77, lat, ac, rd);
            begin
                repeat (3) tick();
                check_eq("wait_during_load", cpu_if.CPU_WAIT, 1);
                check_eq("busy_during_wait", BUSY, 1);
            end
        join
        check_eq("cpu_after_done", ac, last_done_cyc + 2);
        check_eq("cpu_wait_long", 32'(lat > 40), 1);
        check_eq("wait_cleared", cpu_if.CPU_WAIT, 0);
        check_eq("cpu_load_drain", sb.size(), 0);

        tick();
        d0 = done_cnt;
        push_load(2'd1, 5'd12);
        push_load(2'd2, 5'd12);
        pulse_load(2'd1);
        repeat (10) tick();
        pulse_load(2'd2);
        wait_done("b2b_first");
        tick();
        check_eq("b2b_restart", BUSY, 1);
        check_eq("b2b_mode2_addr", TBL_ADDR, 6'h20);
        wait_done("b2b_second");
        check_eq("b2b_busy_len", busy_len, 49);
        repeat (5) tick();
        check_eq("b2b_done_cnt", done_cnt - d0, 2);
        check_eq("b2b_drain", sb.size(), 0);

        push_load(2'd2, 5'd12);
        pulse_load(2'd2);
        repeat (19) tick();
        @(negedge CLOCK);
        #2 RESET = 1'b1;
        #1;
        check_eq("async_rst_bus", {CRTC_ENABLE, CRTC_nCS, CRTC_R_nW, CRTC_RS, CRTC_DI}, 12'h600);
        check_eq("async_rst_busy_tbl", {BUSY, TBL_ADDR}, 7'h0);
        sb.delete();
        tick(); tick();
        push_load(2'd0, 5'd0);
        RESET = 1'b0;
        wait_done("rst_reload_done");
        check_eq("rst_reload_busy_len", busy_len, 49);
        check_eq("rst_reload_drain", sb.size(), 0);

`ifdef CRTC_LOADER_VSYNC_ALIGN_EN
        tick();
        n0 = n_bus;
        push_load(2'd1, 5'd0);
        pulse_load(2'd1);
        repeat (100) tick();
        check_eq("arm_busy", BUSY, 1);
        check_eq("arm_no_bus", n_bus - n0, 0);
        VSYNC = 1'b1;
        vc = cyc;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (CRTC_ENABLE) break;
        end
        check_eq("vsync_first_write", cyc - vc, 2);
        wait_done("vsync_done");
        check_eq("vsync_drain", sb.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crtc_mode_loader.md
Name: crtc_mode_loader

Overview:
- Configuration sequencer and bus arbiter in front of the UM6845R-style CRTC register port.
- On reset or on request, it streams a 16-register mode table from an external table ROM into the CRTC using address and data write cycles.
- While no load is running, it passes CPU register accesses through, one at a time, so the CPU and the loader never collide on the CRTC bus.
- It shadows the CPU's last register-select write and restores it after a load, so the CPU's view of the address register is preserved.

Parameters:
- MODE_W, 2, width of the mode selector; the table ROM holds 2^MODE_W tables.
- NUM_REGS, 16, number of CRTC registers loaded per table (indices 0..NUM_REGS-1).
- AUTOLOAD, 1, when 1 a load of RESET_MODE starts automatically after reset release.
- RESET_MODE, 0, mode loaded by the autoload.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  reset, asynchronous, active-high.
- MODE_SEL  in  MODE_W  mode table to load; sampled when a load is accepted.
- MODE_LOAD  in  1  single-cycle load request.
- BUSY  out  1  load in progress.
- DONE  out  1  one-cycle pulse when a load completes.
- TBL_ADDR  out  MODE_W+4  {mode, register index} address to the table ROM.
- TBL_DATA  in  8  table ROM data, valid one cycle after TBL_ADDR.
- CPU_REQ  in  1  CPU access request; held high until CPU_ACK.
- CPU_WE  in  1  1 = write, 0 = read.
- CPU_RS  in  1  CRTC register-select line from the CPU.
- CPU_DI  in  8  CPU write data.
- CPU_DO  out  8  CPU read data; valid while CPU_ACK is high.
- CPU_ACK  out  1  one-cycle access-complete pulse.
- CPU_WAIT  out  1  high while CPU_REQ is pending and not yet serviced.
- CRTC_ENABLE, CRTC_nCS, CRTC_R_nW, CRTC_RS  out  1 each  CRTC bus control.
- CRTC_DI  out  8  CRTC write data.
- CRTC_DO  in  8  CRTC read data (combinational on the CRTC side).
- VSYNC  in  1  CRTC VSYNC; used only when VSYNC_ALIGN_EN is defined.

Behaviour:
- Reset values (all outputs are registered): BUSY=0, DONE=0, CPU_ACK=0, CPU_DO=0, CRTC_ENABLE=0, CRTC_nCS=1, CRTC_R_nW=1, CRTC_RS=0, CRTC_DI=0, TBL_ADDR=0, shadow address register=0, idx=0.
- States: IDLE, FETCH, WR_ADDR, WR_DATA, RESTORE, CPU_CYC, ARM (ARM exists only with the optional feature).
- IDLE:
  - A pending load (MODE_LOAD, or the autoload flag) has priority over CPU_REQ.
  - Accepting a load latches the mode, sets idx=0, BUSY=1, and moves to FETCH.
  - Otherwise, CPU_REQ latches WE/RS/DI and moves to CPU_CYC.
- FETCH: drive TBL_ADDR={mode,idx}; the CRTC bus is idle; go to WR_ADDR.
- WR_ADDR: one bus write cycle: ENABLE=1, nCS=0, R_nW=0, RS=0, DI=idx (zero-extended). TBL_DATA is captured in this cycle. Go to WR_DATA.
- WR_DATA: one bus write cycle with RS=1 and DI=captured TBL_DATA.
  - If idx==NUM_REGS-1, go to RESTORE.
  - Otherwise idx++ and go to FETCH.
- RESTORE: write cycle with RS=0, DI=shadow address; then IDLE, BUSY=0, DONE=1 for one cycle.
- Load timing: BUSY is high for exactly 3*NUM_REGS+1 = 49 cycles; DONE is asserted on the cycle after RESTORE.
- CPU_CYC: one bus cycle: ENABLE=1, nCS=0, R_nW=~WE, RS=latched RS, DI=latched DI.
  - For a read, CPU_DO is captured from CRTC_DO.
  - On an RS=0 write, the shadow address register is updated to DI[4:0].
  - Next cycle: CPU_ACK=1, return to IDLE. Latency is 2 cycles from REQ sampled in IDLE to ACK.
- CPU_REQ during a load: CPU_WAIT=1 until the access enters CPU_CYC. CPU_REQ is not re-sampled while ACK is high.
- MODE_LOAD during a load: stored as one pending request (the latest MODE_SEL wins) and started immediately after DONE, ahead of any CPU request. Further requests overwrite the pending one.
- Simultaneous MODE_LOAD and CPU_REQ in IDLE: the load wins and the CPU waits about 50 cycles.
- RESET mid-load: asynchronous return to reset values. With AUTOLOAD=1 a full reload of RESET_MODE follows; no partial-resume state is kept.
- Outside an active bus cycle, ENABLE=0, nCS=1, R_nW=1.

Optional Feature:
- CRTC_LOADER_VSYNC_ALIGN_EN defined: an accepted load enters ARM and waits for a VSYNC rising edge (a registered previous-VSYNC sample is compared with the current value) before FETCH.
  - BUSY is high during ARM.
  - CPU accesses remain blocked during ARM.
  - Autoload after reset skips ARM.
- Not defined: ARM is absent, the VSYNC input is ignored, and FETCH follows immediately.

Decomposition:
- Shared package crtc_pkg holds:
  - the state enum;
  - CRTC_NUM_REGS=16;
  - the register index constants R_HTOTAL=0 … R_CURSOR_L=15;
  - the bus idle constants.
- Single module; no sub-module is warranted. Bus output registering stays in the same always block as the FSM.

Test Plan:
- Reset release with AUTOLOAD=1, ROM table m0 = 0x3F,0x28,0x2E,0x8E,0x26,0x00,0x19,0x1E,0x00,0x07,… → 32 CRTC writes in order (idx k then data k), then a RESTORE write of 0x00; BUSY high for 49 cycles; one DONE pulse.
- CPU write RS=0 DI=0x0C, then RS=1 DI=0x30 → CRTC sees the two writes; each ACK arrives 2 cycles after REQ is sampled; shadow=12.
- Shadow=12, then MODE_LOAD mode 1 → the final RESTORE write has RS=0 and DI=0x0C.
- CPU_REQ asserted 5 cycles into a load → CPU_WAIT high until the load ends; the CPU_CYC bus cycle occurs right after DONE; no interleaving.
- Second MODE_LOAD (mode 2) during a mode-1 load → mode 2 starts in the cycle after DONE; exactly two DONE pulses.
- RESET asserted at cycle 20 of a load → outputs take their reset values asynchronously; a fresh autoload begins at idx 0.
- With CRTC_LOADER_VSYNC_ALIGN_EN: MODE_LOAD, then VSYNC rises 100 cycles later → the first CRTC write occurs 2 cycles after the edge.
